// File: rtl/cache_data_flush.sv
// -----------------------------------------------------------------------------
// cache_data_flush
//
// Parametrised cache data array with a per-line dirty array and a flush
// engine. The access side supports word and byte partial writes, full-line
// fills and a 1-cycle read whose line is presented both unshifted and shifted
// down by the registered word offset. The flush engine walks every line
// index {way, segment} in ascending order. Each dirty line is streamed out over
// a valid/ready write-back port, and its dirty bit is cleared on acceptance.
//
// Ports
//   main_clk, main_rst_n        clock, asynchronous active-low reset
//   target_segment, target_way  access line address
//   do_partial_write            word/byte write (blocked by any_fault)
//   do_full_write               line fill from raw_in_full_data (wins over partial)
//   any_fault                   suppresses a partial write in the same cycle
//   do_byte_operation           byte access on word word_offset
//   byte_operation_polarity     0 = low byte, 1 = high byte
//   word_offset, access_length  first word and word count minus 1
//   access_in_full_data         partial-write words, word 0 in the LSBs
//   raw_in_full_data            fill line
//   access_out_full_data        read line shifted down by the registered offset
//   raw_out_full_data           read line, unshifted
//   out_dirty                   dirty flag of the last addressed line (pre-write)
//   flush_start                 begins a scan when idle
//   flush_busy, flush_done      engine active / 1-cycle end-of-scan pulse
//   wb_valid, wb_ready          write-back handshake
//   wb_way, wb_segment, wb_data address and contents of the presented line
// -----------------------------------------------------------------------------
module cache_data_flush #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ACCESS_WORDS   = 4,
  parameter int WAYS           = 4,
  parameter int SEGMENTS       = 512,
  localparam int LINE_BITS     = 16 * WORDS_PER_LINE,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int WAY_W         = $clog2(WAYS),
  localparam int SEG_W         = $clog2(SEGMENTS)
) (
  input  logic                      main_clk,
  input  logic                      main_rst_n,
  input  logic [SEG_W-1:0]          target_segment,
  input  logic [WAY_W-1:0]          target_way,
  input  logic                      do_partial_write,
  input  logic                      do_full_write,
  input  logic                      any_fault,
  input  logic                      do_byte_operation,
  input  logic                      byte_operation_polarity,
  input  logic [OFF_W-1:0]          word_offset,
  input  logic [OFF_W-1:0]          access_length,
  input  logic [16*ACCESS_WORDS-1:0] access_in_full_data,
  input  logic [LINE_BITS-1:0]      raw_in_full_data,
  output logic [LINE_BITS-1:0]      access_out_full_data,
  output logic [LINE_BITS-1:0]      raw_out_full_data,
  output logic                      out_dirty,
  input  logic                      flush_start,
  output logic                      flush_busy,
  output logic                      flush_done,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [WAY_W-1:0]          wb_way,
  output logic [SEG_W-1:0]          wb_segment,
  output logic [LINE_BITS-1:0]      wb_data
);

  localparam int LINES   = WAYS * SEGMENTS;
  localparam int IDX_W   = WAY_W + SEG_W;
  localparam int BYTES   = 2 * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_PRESENT,
    S_DONE
  } state_t;

  // Storage
  logic [LINE_BITS-1:0] mem_q [LINES];
  logic [LINES-1:0]     dirty_q;

  // Flush engine state (all registered outputs)
  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 wb_valid_q;
  logic [WAY_W-1:0]     wb_way_q;
  logic [SEG_W-1:0]     wb_seg_q;
  logic [LINE_BITS-1:0] wb_data_q;

  // Read-side registers
  logic [LINE_BITS-1:0] acc_line_q;
  logic [OFF_W-1:0]     off_q;
  logic                 byte_q;
  logic                 pol_q;
  logic                 out_dirty_q;

  // Access decode
  logic [IDX_W-1:0]     acc_idx;
  logic                 wr_full;
  logic                 wr_part;
  logic [BYTES-1:0]     byte_en;
  logic [LINE_BITS-1:0] wr_data;
  logic                 last_idx;
  logic                 scan_dirty;
  logic                 wb_fire;
  logic [LINE_BITS-1:0] line_shifted;

  assign acc_idx    = {target_way, target_segment};
  assign idx_d      = idx_q + IDX_W'(1);
  assign last_idx   = (idx_q == IDX_W'(LINES - 1));
  assign scan_dirty = (state_q == S_SCAN) && dirty_q[idx_q];
  assign wb_fire    = (state_q == S_PRESENT) && wb_ready;

  // The access side is frozen for the whole flush, so the engine never
  // contends with a controller write for the array or the dirty bits.
  assign wr_full = !busy_q && do_full_write;
  assign wr_part = !busy_q && do_partial_write && !any_fault && !do_full_write;

  // Byte-lane enables and aligned write data for the selected write kind.
  // Word writes are clipped at the line end rather than wrapping.
  always_comb begin
    int off;
    byte_en = '0;
    wr_data = '0;
    off     = int'(word_offset);
    if (wr_full) begin
      byte_en = '1;
      wr_data = raw_in_full_data;
    end else if (wr_part) begin
      if (do_byte_operation) begin
        byte_en[2*off + int'(byte_operation_polarity)] = 1'b1;
        wr_data[16*off + 8*int'(byte_operation_polarity) +: 8] = access_in_full_data[7:0];
      end else begin
        for (int k = 0; k < ACCESS_WORDS; k++) begin
          if (k <= int'(access_length) && (off + k) < WORDS_PER_LINE) begin
            byte_en[2*(off+k) +: 2]  = 2'b11;
            wr_data[16*(off+k) +: 16] = access_in_full_data[16*k +: 16];
          end
        end
      end
    end
  end

  // ---- stage boundary: array write / read registers (data, not reset) ----
  always_ff @(posedge main_clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (byte_en[b]) begin
        mem_q[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    // Non-blocking read gives read-old behaviour on a same-address write.
    if (!busy_q) begin
      acc_line_q <= mem_q[acc_idx];
    end
    if (scan_dirty) begin
      wb_data_q <= mem_q[idx_q];
    end
  end

  // ---- stage boundary: registered read control ----
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      off_q       <= '0;
      byte_q      <= 1'b0;
      pol_q       <= 1'b0;
      out_dirty_q <= 1'b0;
    end else if (!busy_q) begin
      off_q       <= word_offset;
      byte_q      <= do_byte_operation;
      pol_q       <= byte_operation_polarity;
      out_dirty_q <= dirty_q[acc_idx];
    end
  end

  // ---- stage boundary: dirty array ----
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      dirty_q <= '0;
    end else begin
      if (wr_full) begin
        dirty_q[acc_idx] <= 1'b0;
      end else if (wr_part) begin
        dirty_q[acc_idx] <= 1'b1;
      end
      if (wb_fire) begin
        dirty_q[idx_q] <= 1'b0;
      end
    end
  end

  // ---- stage boundary: flush engine ----
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_way_q   <= '0;
      wb_seg_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush_start) begin
            state_q <= S_SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (dirty_q[idx_q]) begin
            // Array read is issued this cycle; address travels with it.
            state_q  <= S_READ;
            wb_way_q <= idx_q[IDX_W-1 -: WAY_W];
            wb_seg_q <= idx_q[SEG_W-1:0];
          end else if (last_idx) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_d;
          end
        end
        S_READ: begin
          state_q    <= S_PRESENT;
          wb_valid_q <= 1'b1;
        end
        S_PRESENT: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            if (last_idx) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SCAN;
              idx_q   <= idx_d;
            end
          end
        end
        S_DONE: begin
          // busy stays high through DONE so a start in this cycle is ignored.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage boundary: output shaping ----
  // Right shift fills vacated upper words with zeros.
  assign line_shifted = acc_line_q >> {off_q, 4'b0000};

  always_comb begin
    access_out_full_data = '0;
    if (byte_q) begin
      access_out_full_data[7:0] = pol_q ? line_shifted[15:8] : line_shifted[7:0];
    end else begin
      access_out_full_data = line_shifted;
    end
  end

  assign raw_out_full_data = acc_line_q;
  assign out_dirty         = out_dirty_q;
  assign flush_busy        = busy_q;
  assign flush_done        = done_q;
  assign wb_valid          = wb_valid_q;
  assign wb_way            = wb_way_q;
  assign wb_segment        = wb_seg_q;
  assign wb_data           = wb_data_q;

endmodule

// File: tb/tb_cache_data_flush.sv
// Bench for cache_data_flush: a line-level model (arrays of lines and dirty
// bits plus an expected write-back queue) checked every negative edge, and
// directed vectors with hand-computed literal expectations.
module tb_cache_data_flush;

  localparam int WPL   = 8;
  localparam int AW    = 4;
  localparam int LINES = 2048;

  logic         clk;
  logic         rst_n;
  logic [8:0]   target_segment;
  logic [1:0]   target_way;
  logic         do_partial_write, do_full_write, any_fault;
  logic         do_byte_operation, byte_operation_polarity;
  logic [2:0]   word_offset, access_length;
  logic [63:0]  access_in_full_data;
  logic [127:0] raw_in_full_data;
  logic [127:0] access_out_full_data, raw_out_full_data;
  logic         out_dirty;
  logic         flush_start, flush_busy, flush_done;
  logic         wb_valid, wb_ready;
  logic [1:0]   wb_way;
  logic [8:0]   wb_segment;
  logic [127:0] wb_data;

  cache_data_flush dut (
    .main_clk                (clk),
    .main_rst_n              (rst_n),
    .target_segment          (target_segment),
    .target_way              (target_way),
    .do_partial_write        (do_partial_write),
    .do_full_write           (do_full_write),
    .any_fault               (any_fault),
    .do_byte_operation       (do_byte_operation),
    .byte_operation_polarity (byte_operation_polarity),
    .word_offset             (word_offset),
    .access_length           (access_length),
    .access_in_full_data     (access_in_full_data),
    .raw_in_full_data        (raw_in_full_data),
    .access_out_full_data    (access_out_full_data),
    .raw_out_full_data       (raw_out_full_data),
    .out_dirty               (out_dirty),
    .flush_start             (flush_start),
    .flush_busy              (flush_busy),
    .flush_done              (flush_done),
    .wb_valid                (wb_valid),
    .wb_ready                (wb_ready),
    .wb_way                  (wb_way),
    .wb_segment              (wb_segment),
    .wb_data                 (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [127:0] m_line  [LINES];
  bit           m_known [LINES];
  bit           m_dirty [LINES];
  int           wbq[$];
  bit           exp_busy = 0;
  bit           exp_odirty = 0;
  bit           exp_known = 0;
  logic [127:0] exp_raw = '0;
  int           exp_off = 0;
  bit           exp_byte = 0;
  bit           exp_pol = 0;

  initial begin
    foreach (m_known[i]) begin m_known[i] = 0; m_dirty[i] = 0; m_line[i] = '0; end
  end

  function automatic logic [127:0] model_access(logic [127:0] line, int off, bit byt, bit pol);
    logic [127:0] r;
    r = '0;
    if (byt) begin
      r[7:0] = pol ? line[16*off+8 +: 8] : line[16*off +: 8];
    end else begin
      for (int j = 0; j < WPL; j++)
        if (off + j < WPL) r[16*j +: 16] = line[16*(off+j) +: 16];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", flush_busy, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_done", flush_done, 0);
      chk("rst_out_dirty", out_dirty, 0);
      foreach (m_dirty[i]) m_dirty[i] = 0;
      wbq.delete();
      exp_busy = 0; exp_odirty = 0; exp_known = 0;
      exp_off = 0; exp_byte = 0; exp_pol = 0;
    end else begin
      chk("busy", flush_busy, exp_busy);
      chk("out_dirty", out_dirty, exp_odirty);
      if (exp_known) begin
        chk("raw_out", raw_out_full_data, exp_raw);
        chk("access_out", access_out_full_data, model_access(exp_raw, exp_off, exp_byte, exp_pol));
      end
      if (wb_valid) begin
        chk("wb_pending", wbq.size() != 0, 1);
        if (wbq.size() != 0) begin
          chk("wb_data", wb_data, m_line[wbq[0]]);
          chk("wb_way", wb_way, wbq[0] / 512);
          chk("wb_segment", wb_segment, wbq[0] % 512);
        end
      end
      if (flush_done) chk("done_drained", wbq.size(), 0);
      // predict the effect of the coming rising edge
      if (exp_busy) begin
        if (flush_done) exp_busy = 0;
        else if (wb_valid && wb_ready && wbq.size() != 0) begin
          m_dirty[wbq[0]] = 0;
          void'(wbq.pop_front());
        end
      end else begin
        int a, off;
        a = int'({target_way, target_segment});
        off = int'(word_offset);
        exp_raw = m_line[a]; exp_known = m_known[a]; exp_odirty = m_dirty[a];
        exp_off = off; exp_byte = do_byte_operation; exp_pol = byte_operation_polarity;
        if (do_full_write) begin
          m_line[a] = raw_in_full_data; m_known[a] = 1; m_dirty[a] = 0;
        end else if (do_partial_write && !any_fault) begin
          if (do_byte_operation)
            m_line[a][16*off + 8*int'(byte_operation_polarity) +: 8] = access_in_full_data[7:0];
          else
            for (int k = 0; k <= int'(access_length) && k < AW; k++)
              if (off + k < WPL) m_line[a][16*(off+k) +: 16] = access_in_full_data[16*k +: 16];
          m_dirty[a] = 1;
        end
        if (flush_start) begin
          exp_busy = 1;
          for (int i = 0; i < LINES; i++) if (m_dirty[i]) wbq.push_back(i);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    do_partial_write = 0; do_full_write = 0; any_fault = 0;
    do_byte_operation = 0; byte_operation_polarity = 0;
    word_offset = 0; access_length = 0;
    access_in_full_data = '0; raw_in_full_data = '0; flush_start = 0;
  endtask

  task automatic full_wr(input logic [1:0] w, input logic [8:0] s, input logic [127:0] d);
    idle_in();
    target_way = w; target_segment = s; do_full_write = 1; raw_in_full_data = d;
    tick();
    idle_in();
  endtask

  task automatic part_wr(input logic [1:0] w, input logic [8:0] s, input logic [2:0] off,
                         input logic [2:0] len, input logic [63:0] d, input bit f,
                         input bit b, input bit p);
    idle_in();
    target_way = w; target_segment = s; word_offset = off; access_length = len;
    access_in_full_data = d; any_fault = f; do_byte_operation = b;
    byte_operation_polarity = p; do_partial_write = 1;
    tick();
    idle_in();
  endtask

  task automatic rd(input logic [1:0] w, input logic [8:0] s, input logic [2:0] off,
                    input bit b, input bit p);
    idle_in();
    target_way = w; target_segment = s; word_offset = off;
    do_byte_operation = b; byte_operation_polarity = p;
    tick();
  endtask

  int emitted[$];

  task automatic run_flush(input int stall, input bit inject, output int cycles);
    int stalled;
    stalled = 0;
    emitted.delete();
    wb_ready = (stall == 0);
    flush_start = 1;
    tick();
    flush_start = 0;
    cycles = 1;
    while (!flush_done && cycles < 6000) begin
      if (inject && cycles == 3) begin
        target_way = 1; target_segment = 5; word_offset = 0; access_length = 0;
        access_in_full_data = 64'h0BAD; do_partial_write = 1;
      end else do_partial_write = 0;
      flush_start = (cycles == 10);
      if (wb_valid && !wb_ready) begin
        chk("stall_data", wb_data, 128'h0007);
        chk("stall_way", wb_way, 0);
        chk("stall_seg", wb_segment, 7);
        stalled++;
        if (stalled == stall) wb_ready = 1;
      end
      if (wb_valid && wb_ready) emitted.push_back(int'({wb_way, wb_segment}));
      tick();
      cycles++;
    end
    flush_start = 0; do_partial_write = 0;
    if (!flush_done) begin
      n_vec++; n_err++;
      $display("FAIL flush_timeout: got no flush_done after %0d cycles", cycles);
    end
    tick();
    wb_ready = 1;
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [127:0] L = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    int cyc, cnt;
    int exp_e[3];
    exp_e[0] = 7; exp_e[1] = 1024; exp_e[2] = 2047;
    rst_n = 0; wb_ready = 1; target_way = 0; target_segment = 0;
    idle_in();
    #22;
    chk("reset_busy", flush_busy, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_done", flush_done, 0);
    chk("reset_out_dirty", out_dirty, 0);
    rst_n = 1;
    tick();

    // clean read, then a flush of an all-clean array
    rd(0, 5, 0, 0, 0);
    chk("clean_read_dirty", out_dirty, 0);
    run_flush(0, 0, cyc);
    chk("clean_flush_cycles", cyc, 2049);
    chk("clean_flush_emits", emitted.size(), 0);
    chk("clean_flush_idle", flush_busy, 0);

    // full write and shifted read
    full_wr(1, 3, L);
    rd(1, 3, 2, 0, 0);
    chk("shift2_out", access_out_full_data, 128'h0000_0000_0123_4567_89AB_CDEF_FEDC_BA98);
    chk("shift2_word0", access_out_full_data[15:0], 16'hBA98);
    chk("shift2_dirty", out_dirty, 0);

    // truncated word write, read-old on the same cycle
    part_wr(1, 3, 6, 3, 64'h4444_3333_2222_1111, 0, 0, 0);
    chk("readold_raw", raw_out_full_data, L);
    chk("readold_dirty", out_dirty, 0);
    rd(1, 3, 0, 0, 0);
    chk("partial_raw", raw_out_full_data, 128'h2222_1111_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("partial_dirty", out_dirty, 1);

    // faulted partial write is dropped
    full_wr(1, 4, L);
    part_wr(1, 4, 6, 3, 64'h4444_3333_2222_1111, 1, 0, 0);
    rd(1, 4, 0, 0, 0);
    chk("fault_raw", raw_out_full_data, L);
    chk("fault_dirty", out_dirty, 0);

    // byte write high lane, byte reads of both lanes
    part_wr(1, 4, 4, 7, 64'hFFFF_FFFF_FFFF_FFA5, 0, 1, 1);
    rd(1, 4, 4, 1, 1);
    chk("byte_hi_out", access_out_full_data, 128'h00A5);
    chk("byte_raw", raw_out_full_data, 128'h0123_4567_89AB_A5EF_FEDC_BA98_7654_3210);
    chk("byte_dirty", out_dirty, 1);
    rd(1, 4, 4, 1, 0);
    chk("byte_lo_out", access_out_full_data, 128'h00EF);

    // full and partial together: the fill wins and cleans the line
    idle_in();
    target_way = 1; target_segment = 4; do_full_write = 1; raw_in_full_data = L;
    do_partial_write = 1; access_in_full_data = 64'hFFFF;
    tick();
    rd(1, 4, 0, 0, 0);
    chk("full_wins_raw", raw_out_full_data, L);
    chk("full_wins_dirty", out_dirty, 0);
    full_wr(1, 3, L);

    // three dirty lines, first one stalled for 5 cycles
    full_wr(0, 7, '0);   part_wr(0, 7, 0, 0, 64'h0007, 0, 0, 0);
    full_wr(2, 0, '0);   part_wr(2, 0, 0, 0, 64'h2000, 0, 0, 0);
    full_wr(3, 511, '0); part_wr(3, 511, 0, 0, 64'h31FF, 0, 0, 0);
    run_flush(5, 1, cyc);
    chk("flush3_count", emitted.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("flush3_order%0d", i), (i < emitted.size()) ? emitted[i] : -1, exp_e[i]);
    rd(0, 7, 0, 0, 0);   chk("after_dirty_0_7", out_dirty, 0);
    rd(2, 0, 0, 0, 0);   chk("after_dirty_2_0", out_dirty, 0);
    chk("after_raw_2_0", raw_out_full_data, 128'h2000);
    rd(3, 511, 0, 0, 0); chk("after_dirty_3_511", out_dirty, 0);
    rd(1, 5, 0, 0, 0);   chk("busy_write_ignored", out_dirty, 0);
    run_flush(0, 0, cyc);
    chk("second_flush_emits", emitted.size(), 0);
    chk("second_flush_cycles", cyc, 2049);

    // asynchronous reset while presenting a line
    part_wr(2, 0, 0, 0, 64'h2000, 0, 0, 0);
    wb_ready = 0;
    flush_start = 1;
    tick();
    flush_start = 0;
    cnt = 0;
    while (!wb_valid && cnt < 5000) begin tick(); cnt++; end
    chk("abort_reached_present", wb_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", flush_busy, 0);
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_done", flush_done, 0);
    @(negedge clk);
    #1 rst_n = 1;
    wb_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", flush_done, 0);
    end
    run_flush(0, 0, cyc);
    chk("abort_flush_emits", emitted.size(), 0);
    chk("abort_flush_cycles", cyc, 2049);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_data_flush.md
Name: cache_data_flush

Overview:
- Parametrised successor to the single-configuration cache data array. Same access semantics: word and byte partial writes, full-line fills and shifted read-out.
- Generalised in line width, access width, way count and segment count.
- Adds a resettable per-line dirty array and a flush engine. The engine scans every line and streams dirty lines out over a valid/ready write-back port.
- Sits between the cache controller (access side) and the memory write-back path.

Parameters:
- WORDS_PER_LINE, 8, 16-bit words per line (power of 2, ≥2); LINE_BITS=16*WORDS_PER_LINE, OFF_W=log2(WORDS_PER_LINE).
- ACCESS_WORDS, 4, words in access_in_full_data (1..WORDS_PER_LINE).
- WAYS, 4, ways (power of 2); WAY_W=log2(WAYS).
- SEGMENTS, 512, sets per way (power of 2); SEG_W=log2(SEGMENTS).

Ports:
- main_clk  in  1  clock, all state on rising edge
- main_rst_n  in  1  asynchronous, active-low reset
- target_segment  in  SEG_W  access set index
- target_way  in  WAY_W  access way
- do_partial_write  in  1  word/byte write, suppressed by any_fault
- do_full_write  in  1  line fill from raw_in_full_data; ignores any_fault
- any_fault  in  1  blocks partial write in the same cycle
- do_byte_operation  in  1  byte access on word word_offset
- byte_operation_polarity  in  1  0=low byte, 1=high byte
- word_offset  in  OFF_W  first word of access
- access_length  in  OFF_W  words accessed minus 1
- access_in_full_data  in  16*ACCESS_WORDS  write words, word 0 in LSBs
- raw_in_full_data  in  LINE_BITS  fill line
- access_out_full_data  out  LINE_BITS  line shifted down by registered word_offset
- raw_out_full_data  out  LINE_BITS  unshifted line
- out_dirty  out  1  dirty flag of last addressed line
- flush_start  in  1  pulse; begins a scan when idle
- flush_busy  out  1  engine active
- flush_done  out  1  1-cycle pulse at scan end
- wb_valid  out  1  write-back line valid
- wb_ready  in  1  write-back accept
- wb_way  out  WAY_W  way of wb_data
- wb_segment  out  SEG_W  segment of wb_data
- wb_data  out  LINE_BITS  dirty line contents

Behaviour:
Reset
- Reset clears all dirty bits, FSM to IDLE, and flush_busy, flush_done and wb_valid to 0.
- out_dirty, the wb_* address fields and the registered read control reset to 0. Data array contents are not reset.

Reads
- 1-cycle latency. Data is read-old on same-address write; out_dirty is also the pre-write value.
- Words of access_out_full_data beyond WORDS_PER_LINE-offset_r are 0 (defined, not x).
- Byte read: word 0 carries the selected byte zero-extended to 16 bits.

Writes
- A write occurs when do_full_write=1, or when do_partial_write=1 and any_fault=0.
- Full write: all bytes, data=raw_in_full_data, clears the line's dirty bit.
- Partial write sets the line's dirty bit.
- Word write enables words word_offset .. word_offset+min(access_length, ACCESS_WORDS-1). Enables are truncated at the line end; there is no wrap.
- Byte write: only word word_offset, one byte lane per polarity, data access_in_full_data[7:0]. access_length is ignored.
- Full and partial asserted together: the full write wins.

Flush FSM (IDLE, SCAN, READ, PRESENT, DONE)
- Line index i = {way, segment}, run from 0 to WAYS*SEGMENTS-1.
- IDLE: flush_start → SCAN with i=0 and flush_busy=1. flush_start while busy is ignored.
- SCAN: 1 line per cycle. Clean line: i++. Dirty line: issue an array read → READ.
- READ: next cycle → PRESENT. wb_data, wb_way and wb_segment are captured and held stable.
- PRESENT: wb_valid=1 until wb_ready. On handshake: clear the dirty bit, i++, → SCAN.
- After the last index → DONE. DONE pulses flush_done, deasserts flush_busy, → IDLE.
- While flush_busy=1, all access-side writes and reads are ignored: array, dirty bits and out_* are unchanged. The controller must stall.
- Async reset mid-flush aborts immediately. No flush_done, dirty bits cleared.

Test Plan:
- Reset, then read way 0 seg 5 → out_dirty=0; flush_start → flush_done after 2048+1 cycles, wb_valid never asserted.
- Full write way1 seg3 line=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, read offset 2 → access word0=16'hBA98, words 6,7=0, out_dirty=0.
- Partial write offset 6, length 3, data {4444,3333,2222,1111} → only words 6,7 = 1111,2222; dirty=1. Same write with any_fault=1 → no change, dirty=0.
- Byte write polarity 1, offset 4, data 8'hA5 → word4[15:8]=A5 and [7:0] unchanged; byte read → word0=16'h00A5.
- Mark 3 lines dirty ({0,7},{2,0},{3,511}), flush with wb_ready low for 5 cycles on the first → lines emitted in index order, wb_data held while stalled. Afterward all out_dirty=0 and a second flush emits nothing.
- Assert main_rst_n=0 while in PRESENT → wb_valid and flush_busy drop asynchronously, no flush_done; a subsequent flush emits no lines.
